// File: rtl/audio_round_sequencer.sv
// Purpose : calibrates the ADC bias, then runs one fixed-slot datapath round per ADC sample.
// Latency : adc_valid in WAIT -> counter=0 next cycle; a round is SEND_SLOT+1 cycles with send_ready high.
// Backpressure: counter and send_valid hold at SEND_SLOT until send_ready; samples arriving mid-round are dropped and flagged.
// Ports   : clk/reset (async, active-high); adc_valid/adc_data (sample in); start_cal (recalibrate request);
//           send_ready (Pi link accept); overrun_clr; counter/sample_voltage/offset (to datapath);
//           cal_done, buf_we, send_valid, busy, overrun (status and strobes, all registered).
module audio_round_sequencer #(
   parameter int         CAL_LOG2   = 6,
   parameter logic [9:0] WRITE_SLOT = 10'd5,
   parameter logic [9:0] SEND_SLOT  = 10'd6,
   parameter logic [9:0] IDLE_COUNT = 10'h3FF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       adc_valid,
   input  logic [9:0] adc_data,
   input  logic       start_cal,
   input  logic       send_ready,
   input  logic       overrun_clr,
   output logic [9:0] counter,
   output logic [9:0] sample_voltage,
   output logic [9:0] offset,
   output logic       cal_done,
   output logic       buf_we,
   output logic       send_valid,
   output logic       busy,
   output logic       overrun
);
   localparam int ACC_W = 10 + CAL_LOG2;

   typedef enum logic [1:0] {S_CAL, S_WAIT, S_RUN} state_t;

   state_t              state, state_nxt;
   logic [ACC_W-1:0]    acc, acc_nxt, cal_sum;
   logic [CAL_LOG2-1:0] cal_cnt, cal_cnt_nxt;
   logic                recal, recal_nxt;
   logic                cal_last, handshake, want_cal;
   logic [9:0]          counter_nxt, sample_nxt, offset_nxt;
   logic                cal_done_nxt, buf_we_nxt, send_valid_nxt, busy_nxt, overrun_nxt;

   assign cal_sum   = acc + ACC_W'(adc_data);
   // Last calibration sample: the count wraps on this one.
   assign cal_last  = adc_valid && (cal_cnt == '1);
   // send_valid is only ever high in RUN, so this is the end-of-round handshake.
   assign handshake = send_valid && send_ready;
   // A recalibration request in the handshake cycle itself is honoured directly.
   assign want_cal  = recal || start_cal;

   // State and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_CAL;
         acc            <= '0;
         cal_cnt        <= '0;
         recal          <= 1'b0;
         counter        <= IDLE_COUNT;
         sample_voltage <= '0;
         offset         <= '0;
         cal_done       <= 1'b0;
         buf_we         <= 1'b0;
         send_valid     <= 1'b0;
         busy           <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         state          <= state_nxt;
         acc            <= acc_nxt;
         cal_cnt        <= cal_cnt_nxt;
         recal          <= recal_nxt;
         counter        <= counter_nxt;
         sample_voltage <= sample_nxt;
         offset         <= offset_nxt;
         cal_done       <= cal_done_nxt;
         buf_we         <= buf_we_nxt;
         send_valid     <= send_valid_nxt;
         busy           <= busy_nxt;
         overrun        <= overrun_nxt;
      end
   end

   // Next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_CAL:   if (cal_last) state_nxt = S_WAIT;
         S_WAIT:  if (start_cal) state_nxt = S_CAL;
                  else if (adc_valid) state_nxt = S_RUN;
         S_RUN:   if (handshake) state_nxt = want_cal ? S_CAL : S_WAIT;
         default: state_nxt = S_CAL;
      endcase
   end

   // Next values of the registered outputs and calibration state
   always_comb begin
      counter_nxt  = IDLE_COUNT;
      sample_nxt   = sample_voltage;
      offset_nxt   = offset;
      cal_done_nxt = cal_done;
      acc_nxt      = acc;
      cal_cnt_nxt  = cal_cnt;
      recal_nxt    = recal;
      case (state)
         S_CAL: begin
            if (adc_valid) begin
               if (cal_last) begin
                  offset_nxt   = cal_sum[ACC_W-1:CAL_LOG2];
                  cal_done_nxt = 1'b1;
                  acc_nxt      = '0;
                  cal_cnt_nxt  = '0;
               end else begin
                  acc_nxt      = cal_sum;
                  cal_cnt_nxt  = cal_cnt + CAL_LOG2'(1);
               end
            end
         end
         S_WAIT: begin
            if (start_cal) begin
               cal_done_nxt = 1'b0;
               // A coincident sample becomes the first calibration sample.
               if (adc_valid) begin
                  acc_nxt     = ACC_W'(adc_data);
                  cal_cnt_nxt = CAL_LOG2'(1);
               end
            end else if (adc_valid) begin
               sample_nxt  = adc_data;
               counter_nxt = '0;
            end
         end
         S_RUN: begin
            if (handshake) begin
               if (want_cal) cal_done_nxt = 1'b0;
               recal_nxt = 1'b0;
            end else begin
               recal_nxt   = recal || start_cal;
               // Hold at SEND_SLOT while the Pi link stalls.
               counter_nxt = send_valid ? counter : counter + 10'd1;
            end
         end
         default: ;
      endcase
      // IDLE_COUNT never equals a slot, so these are quiet outside a round.
      buf_we_nxt     = (state_nxt == S_RUN) && (counter_nxt == WRITE_SLOT);
      send_valid_nxt = (state_nxt == S_RUN) && (counter_nxt == SEND_SLOT);
      busy_nxt       = (state_nxt == S_RUN);
      // Set has priority over clear.
      if (adc_valid && (state == S_RUN)) overrun_nxt = 1'b1;
      else if (overrun_clr)              overrun_nxt = 1'b0;
      else                               overrun_nxt = overrun;
   end

endmodule

// File: tb/tb_audio_round_sequencer.sv
// Purpose : self-checking bench for audio_round_sequencer (CAL_LOG2=2, slots 5/6).
// Latency : a sample-level model is compared against the DUT on every falling edge.
// Backpressure: directed stalls on send_ready; literal expectations pin the model.
module tb_audio_round_sequencer;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       adc_valid = 1'b0;
   logic [9:0] adc_data = '0;
   logic       start_cal = 1'b0;
   logic       send_ready = 1'b0;
   logic       overrun_clr = 1'b0;
   logic [9:0] counter, sample_voltage, offset;
   logic       cal_done, buf_we, send_valid, busy, overrun;

   int checks = 0;
   int errors = 0;
   int sv_cnt = 0;
   int we_cnt = 0;

   audio_round_sequencer #(
      .CAL_LOG2  (2),
      .WRITE_SLOT(10'd5),
      .SEND_SLOT (10'd6),
      .IDLE_COUNT(10'h3FF)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .adc_valid     (adc_valid),
      .adc_data      (adc_data),
      .start_cal     (start_cal),
      .send_ready    (send_ready),
      .overrun_clr   (overrun_clr),
      .counter       (counter),
      .sample_voltage(sample_voltage),
      .offset        (offset),
      .cal_done      (cal_done),
      .buf_we        (buf_we),
      .send_valid    (send_valid),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Mode plus "position within the round" (-1 = no round); slot strobes follow from position.
   localparam int M_CAL = 0, M_WAIT = 1, M_RUN = 2;
   localparam int CAL_N = 4;
   int         m_mode, m_pos, m_sum;
   bit         m_recal, m_cal_done, m_overrun, m_ovr_set;
   logic [9:0] m_sample, m_offset;
   int         m_cal_q[$];

   task automatic model_reset();
      m_mode = M_CAL; m_pos = -1; m_recal = 0; m_cal_done = 0; m_overrun = 0;
      m_sample = '0; m_offset = '0;
      m_cal_q.delete();
   endtask

   // Advance by one clock using the inputs that the next rising edge will see.
   task automatic model_step();
      m_ovr_set = adc_valid && (m_mode == M_RUN);
      case (m_mode)
         M_CAL: begin
            if (adc_valid) begin
               m_cal_q.push_back(int'(adc_data));
               if (m_cal_q.size() == CAL_N) begin
                  m_sum = 0;
                  foreach (m_cal_q[i]) m_sum += m_cal_q[i];
                  m_offset   = 10'(m_sum / CAL_N);
                  m_cal_done = 1;
                  m_cal_q.delete();
                  m_mode     = M_WAIT;
               end
            end
         end
         M_WAIT: begin
            if (start_cal) begin
               m_cal_done = 0;
               m_mode     = M_CAL;
               if (adc_valid) m_cal_q.push_back(int'(adc_data));
            end else if (adc_valid) begin
               m_sample = adc_data;
               m_pos    = 0;
               m_mode   = M_RUN;
            end
         end
         default: begin
            if (start_cal) m_recal = 1;
            if (m_pos == 6) begin
               if (send_ready) begin
                  m_pos = -1;
                  if (m_recal) begin
                     m_mode     = M_CAL;
                     m_cal_done = 0;
                  end else begin
                     m_mode = M_WAIT;
                  end
                  m_recal = 0;
               end
            end else begin
               m_pos++;
            end
         end
      endcase
      if (m_ovr_set)        m_overrun = 1;
      else if (overrun_clr) m_overrun = 0;
   endtask

   // Per-cycle compare on the falling edge, then advance the model.
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (reset) model_reset();
         check("cyc counter",    counter,        (m_pos < 0) ? 10'h3FF : 10'(m_pos));
         check("cyc sample",     sample_voltage, m_sample);
         check("cyc offset",     offset,         m_offset);
         check_bit("cyc cal_done",   cal_done,   m_cal_done);
         check_bit("cyc buf_we",     buf_we,     (m_mode == M_RUN) && (m_pos == 5));
         check_bit("cyc send_valid", send_valid, (m_mode == M_RUN) && (m_pos == 6));
         check_bit("cyc busy",       busy,       m_mode == M_RUN);
         check_bit("cyc overrun",    overrun,    m_overrun);
         if (send_valid) sv_cnt++;
         if (buf_we)     we_cnt++;
         if (!reset) model_step();
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [9:0] d);
      adc_valid = 1'b1;
      adc_data  = d;
      tick();
      adc_valid = 1'b0;
   endtask

   initial begin
      #1 reset = 1'b1;
      tick();
      tick();
      check("rst counter", counter, 10'h3FF);
      check("rst offset", offset, 10'd0);
      check("rst sample", sample_voltage, 10'd0);
      check_bit("rst cal_done", cal_done, 1'b0);
      check_bit("rst overrun", overrun, 1'b0);
      reset = 1'b0;

      // Calibration: (100+101+102+104)/4 = 101
      pulse(10'd100);
      pulse(10'd101);
      pulse(10'd102);
      check_bit("cal not done yet", cal_done, 1'b0);
      pulse(10'd104);
      check_bit("cal done", cal_done, 1'b1);
      check("cal offset", offset, 10'd101);
      check("cal counter idle", counter, 10'h3FF);

      // Nominal round
      send_ready = 1'b1;
      pulse(10'h200);
      check("nom sample", sample_voltage, 10'h200);
      check("nom counter 0", counter, 10'd0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         check("nom counter", counter, 10'(k));
         check_bit("nom buf_we", buf_we, k == 5);
         check_bit("nom send_valid", send_valid, k == 6);
      end
      tick();
      check("nom counter idle", counter, 10'h3FF);
      check_bit("nom busy low", busy, 1'b0);

      // Backpressure: 10 stalled cycles, handshake in the 11th
      send_ready = 1'b0;
      sv_cnt = 0;
      we_cnt = 0;
      pulse(10'h155);
      repeat (6) tick();
      check("bp counter at send", counter, 10'd6);
      repeat (10) tick();
      check("bp counter held", counter, 10'd6);
      check_bit("bp send_valid held", send_valid, 1'b1);
      send_ready = 1'b1;
      tick();
      check("bp counter idle", counter, 10'h3FF);
      check_bit("bp send_valid low", send_valid, 1'b0);
      check("bp send_valid cycles", 10'(sv_cnt), 10'd11);
      check("bp buf_we cycles", 10'(we_cnt), 10'd1);

      // Overrun
      pulse(10'h0AA);
      repeat (3) tick();
      check("ovr counter 3", counter, 10'd3);
      pulse(10'h3FF);
      check_bit("ovr set", overrun, 1'b1);
      check("ovr sample kept", sample_voltage, 10'h0AA);
      repeat (3) tick();
      check("ovr round done", counter, 10'h3FF);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check_bit("ovr cleared", overrun, 1'b0);
      pulse(10'h010);
      adc_valid = 1'b1;
      adc_data = 10'h002;
      overrun_clr = 1'b1;
      tick();
      adc_valid = 1'b0;
      overrun_clr = 1'b0;
      check_bit("ovr set beats clr", overrun, 1'b1);
      check("ovr sample kept 2", sample_voltage, 10'h010);
      repeat (6) tick();
      check("ovr round2 done", counter, 10'h3FF);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;

      // Deferred recalibration: (200*3+204)/4 = 201
      pulse(10'h123);
      repeat (2) tick();
      start_cal = 1'b1;
      tick();
      start_cal = 1'b0;
      check("recal round continues", counter, 10'd3);
      check_bit("recal cal_done still", cal_done, 1'b1);
      repeat (4) tick();
      check("recal idle", counter, 10'h3FF);
      check_bit("recal cal_done low", cal_done, 1'b0);
      check("recal offset kept", offset, 10'd101);
      pulse(10'd200);
      pulse(10'd200);
      pulse(10'd200);
      check("recal offset still old", offset, 10'd101);
      pulse(10'd204);
      check("recal new offset", offset, 10'd201);
      check_bit("recal done", cal_done, 1'b1);

      // start_cal with adc_valid in WAIT: sample joins calibration, (40+40+40+44)/4 = 41
      adc_valid = 1'b1;
      start_cal = 1'b1;
      adc_data = 10'd40;
      tick();
      adc_valid = 1'b0;
      start_cal = 1'b0;
      check("both: no round", counter, 10'h3FF);
      check_bit("both: cal_done low", cal_done, 1'b0);
      pulse(10'd40);
      pulse(10'd40);
      check_bit("both: not done", cal_done, 1'b0);
      pulse(10'd44);
      check("both: offset", offset, 10'd41);

      // Async reset mid-round with send pending
      send_ready = 1'b0;
      pulse(10'h300);
      repeat (5) tick();
      check("ar counter 5", counter, 10'd5);
      check_bit("ar buf_we", buf_we, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("ar counter", counter, 10'h3FF);
      check("ar sample", sample_voltage, 10'd0);
      check("ar offset", offset, 10'd0);
      check_bit("ar cal_done", cal_done, 1'b0);
      check_bit("ar buf_we low", buf_we, 1'b0);
      check_bit("ar send_valid", send_valid, 1'b0);
      check_bit("ar busy", busy, 1'b0);
      tick();
      reset = 1'b0;
      send_ready = 1'b1;
      // In CAL a sample must not start a round: (5+8+8+8)/4 = 7
      pulse(10'd5);
      check("ar in cal", counter, 10'h3FF);
      pulse(10'd8);
      pulse(10'd8);
      pulse(10'd8);
      check("ar recal offset", offset, 10'd7);
      pulse(10'h001);
      repeat (8) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/audio_round_sequencer.md
Name: audio_round_sequencer

Overview:
- Top-level sequencer for the per-sample audio datapath. Calibrates the ADC bias at startup, then runs one fixed-slot processing round per ADC sample.
- Drives the round counter and latched sample/offset into the effects datapath, issues the ring-buffer write strobe, and hands each processed result to the Pi link with a valid/ready handshake.
- Detects and flags samples that arrive while a round is still in progress.

Parameters:
- CAL_LOG2, 6, log2 of number of ADC samples averaged during calibration (64).
- WRITE_SLOT, 5, counter value on which buf_we is asserted.
- SEND_SLOT, 6, counter value on which send_valid is raised; round ends once this handshake completes.
- IDLE_COUNT, 10'h3FF, counter value driven outside a round; must not equal any datapath slot.

Ports:
- clk  in  1  40 MHz clock
- reset  in  1  asynchronous, active-high
- adc_valid  in  1  one-cycle pulse, new ADC sample on adc_data
- adc_data  in  10  unsigned ADC sample
- start_cal  in  1  one-cycle request to recalibrate
- send_ready  in  1  Pi link accepts current result
- overrun_clr  in  1  clears sticky overrun flag
- counter  out  10  round slot counter to datapath
- sample_voltage  out  10  sample latched for the current round
- offset  out  10  calibrated bias
- cal_done  out  1  high when offset is valid and rounds are enabled
- buf_we  out  1  ring-buffer write strobe, one cycle per round
- send_valid  out  1  datapath result available to Pi link
- busy  out  1  high while state is RUN
- overrun  out  1  sticky: a sample was dropped

Behaviour:
- Reset values:
  - counter=IDLE_COUNT; sample_voltage=0, offset=0.
  - cal_done=0, buf_we=0, send_valid=0, busy=0, overrun=0.
  - Accumulator=0, sample count=0, state=CAL, recal-pending=0.
  - Reset mid-round or mid-calibration aborts immediately to these values.
- States: CAL, WAIT, RUN. All outputs are registered.
- CAL:
  - Each adc_valid adds adc_data (zero-extended) into an accumulator of (10+CAL_LOG2) bits and increments the sample count.
  - On the 2^CAL_LOG2-th sample: offset <= acc >> CAL_LOG2 (truncate), cal_done <= 1, acc and count cleared, next state WAIT.
  - counter=IDLE_COUNT, buf_we=0, send_valid=0 throughout.
  - offset keeps its previous value until the new average completes; cal_done=0 while in CAL.
- WAIT:
  - counter=IDLE_COUNT.
  - adc_valid: sample_voltage <= adc_data, counter <= 0, next state RUN.
  - start_cal: cal_done <= 0, next state CAL.
  - start_cal and adc_valid in the same cycle: calibration wins; the sample is counted as the first calibration sample.
- RUN:
  - counter increments by 1 each cycle from 0.
  - buf_we=1 exactly in the cycle counter==WRITE_SLOT.
  - send_valid rises in the cycle counter==SEND_SLOT. counter holds at SEND_SLOT while send_valid && !send_ready.
  - In the first cycle with send_valid && send_ready: next cycle send_valid=0, counter=IDLE_COUNT, state WAIT (or CAL if recal-pending is set; then clear recal-pending and cal_done).
  - send_ready before SEND_SLOT is ignored.
- Latency: adc_valid in WAIT -> counter=0 next cycle. With send_ready held high, round length is SEND_SLOT+1 cycles and state returns to WAIT on cycle SEND_SLOT+2 after the pulse.
- Overrun:
  - adc_valid while state is RUN: sample dropped, sample_voltage unchanged, overrun <= 1.
  - overrun_clr clears overrun; if set and clear coincide, set wins.
- start_cal during RUN sets recal-pending; the current round completes normally.
- Counter arithmetic is 10-bit; IDLE_COUNT is never reached by incrementing within a round.

Test Plan:
- Calibration (CAL_LOG2=2): after reset, feed adc_valid with 100, 101, 102, 104 -> cal_done=1 and offset=101 the cycle after the 4th pulse; counter stays 3FF throughout.
- Nominal round: in WAIT, adc_valid with adc_data=0x200 and send_ready tied high -> sample_voltage=0x200; counter 0..6 on consecutive cycles; buf_we high only at counter 5; send_valid high only at counter 6; counter back to 3FF.
- Backpressure: send_ready low for 10 cycles after SEND_SLOT -> counter holds at 6 and send_valid stays high for 11 cycles; single buf_we; return to WAIT one cycle after the handshake.
- Overrun: second adc_valid at counter 3 -> overrun=1, sample_voltage unchanged. overrun_clr alone clears it. A simultaneous adc_valid in RUN with overrun_clr leaves overrun=1.
- Deferred recalibration: start_cal at counter 2 -> the round finishes; next state is CAL with cal_done=0 and offset unchanged until 4 new samples complete.
- Async reset at counter 5 with send_valid pending -> all outputs return to their reset values immediately, without waiting for a clock edge; state is CAL.
